hamming_test_sequencer: RTL and testbench



---
 rtl/hamming_test_sequencer_pkg.sv | 9 +
 rtl/hamming_test_sequencer_point_counter.sv | 52 +++++
 rtl/hamming_test_sequencer.sv | 99 +++++++++
 tb/tb_hamming_test_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hamming_test_sequencer_pkg.sv
// hamming_test_sequencer_pkg: shared sweep geometry and FSM state encoding.
package hamming_test_sequencer_pkg;
   localparam int DATA_W     = 4;
   localparam int INDX_W     = 3;
   localparam int NUM_DATA   = 16;
   localparam int NUM_INDX   = 8;
   localparam int NUM_POINTS = NUM_DATA * NUM_INDX;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
endpackage

// File: rtl/hamming_test_sequencer_point_counter.sv
// hamming_test_sequencer_point_counter: settle timer plus data-major/index-minor point walk.
module hamming_test_sequencer_point_counter
   import hamming_test_sequencer_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   output logic [DATA_W-1:0] data_word,
   output logic [INDX_W-1:0] corrupt_indx,
   output logic              last_sample,
   output logic              last_point
);
   localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [INDX_W-1:0] indx_q, indx_d;
   assign last_sample  = cnt_q == CNT_W'(SETTLE - 1);
   assign last_point   = data_q == DATA_W'(NUM_DATA - 1) && indx_q == INDX_W'(NUM_INDX - 1);
   assign data_word    = data_q;
   assign corrupt_indx = indx_q;
   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      indx_d = indx_q;
      if (clear) begin
         cnt_d  = '0;
         data_d = '0;
         indx_d = '0;
      end else if (en) begin
         cnt_d = last_sample ? '0 : cnt_q + 1'b1;
         // the final point holds so the result reflects where the sweep ended
         if (last_sample && !last_point) begin
            indx_d = indx_q + 1'b1;
            data_d = indx_q == INDX_W'(NUM_INDX - 1) ? data_q + 1'b1 : data_q;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         data_q <= '0;
         indx_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
         indx_q <= indx_d;
      end
   end
endmodule

// File: rtl/hamming_test_sequencer.sv
// hamming_test_sequencer: sweeps all data/corruption points through the Hamming chain
// and records pass, a saturating error count and the first failing point.
module hamming_test_sequencer
   import hamming_test_sequencer_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] decoded_data,
   input  logic              err_flag,
   output logic [DATA_W-1:0] data_word,
   output logic [INDX_W-1:0] corrupt_indx,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [DATA_W-1:0] fail_data,
   output logic [INDX_W-1:0] fail_indx
);
   state_t            state_q, state_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic [INDX_W-1:0] fail_indx_q, fail_indx_d;
   logic              first_fail_q, first_fail_d;
   logic              pass_q, pass_d;
   logic              clear, last_sample, last_point, mismatch;
   hamming_test_sequencer_point_counter #(.SETTLE(SETTLE)) u_point_counter (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .en          (state_q == RUN),
      .data_word   (data_word),
      .corrupt_indx(corrupt_indx),
      .last_sample (last_sample),
      .last_point  (last_point)
   );
   assign mismatch  = (decoded_data != data_word) || (err_flag != (corrupt_indx != '0));
   assign busy      = state_q == RUN;
   assign done      = state_q == FINISH;
   assign pass      = pass_q;
   assign err_cnt   = err_cnt_q;
   assign fail_data = fail_data_q;
   assign fail_indx = fail_indx_q;
   always_comb begin
      state_d      = state_q;
      err_cnt_d    = err_cnt_q;
      fail_data_d  = fail_data_q;
      fail_indx_d  = fail_indx_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      clear        = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d      = RUN;
            clear        = 1'b1;
            err_cnt_d    = '0;
            fail_data_d  = '0;
            fail_indx_d  = '0;
            first_fail_d = 1'b0;
            pass_d       = 1'b0;
         end
         RUN: if (last_sample) begin
            if (mismatch) begin
               err_cnt_d    = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
               first_fail_d = 1'b1;
               fail_data_d  = first_fail_q ? fail_data_q : data_word;
               fail_indx_d  = first_fail_q ? fail_indx_q : corrupt_indx;
            end
            // pass must include the final sample, so it is taken from the next count
            if (last_point) begin
               state_d = FINISH;
               pass_d  = err_cnt_d == '0;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         err_cnt_q    <= '0;
         fail_data_q  <= '0;
         fail_indx_q  <= '0;
         first_fail_q <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_cnt_q    <= err_cnt_d;
         fail_data_q  <= fail_data_d;
         fail_indx_q  <= fail_indx_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end
endmodule

// File: tb/tb_hamming_test_sequencer.sv
// tb_hamming_test_sequencer: drives the sequencer through a behavioural Hamming chain
// with injected faults and checks results against a point-by-point reference model.
module tb_hamming_test_sequencer;
   logic         clk = 1'b0;
   logic         reset, start, err_flag;
   logic [3:0]   decoded_data, data_word, fail_data;
   logic [2:0]   corrupt_indx, fail_indx;
   logic         busy, done, pass;
   logic [7:0]   err_cnt;
   logic         start4, busy4, done4, pass4;
   logic [3:0]   dw4, dec4, fd4;
   logic [2:0]   ci4, fi4;
   logic [3:0]   ec4;
   int           n_cmp = 0, n_bad = 0;
   int           mode = 0;
   logic [127:0] fault_mask = '0;

   always #5 clk = ~clk;

   hamming_test_sequencer #(.SETTLE(2), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .decoded_data(decoded_data), .err_flag(err_flag),
      .data_word(data_word), .corrupt_indx(corrupt_indx), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_data(fail_data), .fail_indx(fail_indx)
   );

   hamming_test_sequencer #(.SETTLE(2), .ERR_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .decoded_data(dec4), .err_flag(ci4 != 3'd0),
      .data_word(dw4), .corrupt_indx(ci4), .busy(busy4), .done(done4), .pass(pass4),
      .err_cnt(ec4), .fail_data(fd4), .fail_indx(fi4)
   );
   assign dec4 = ~dw4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ideal encode -> flip -> syndrome-correct, returns {flag, data}
   function automatic logic [4:0] chain(input logic [3:0] d, input logic [2:0] i);
      logic [7:0] c;
      logic [2:0] s;
      c = '0;
      c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
      c[1] = c[3] ^ c[5] ^ c[7];
      c[2] = c[3] ^ c[6] ^ c[7];
      c[4] = c[5] ^ c[6] ^ c[7];
      if (i != 0) c[i] = ~c[i];
      s = {c[4] ^ c[5] ^ c[6] ^ c[7], c[2] ^ c[3] ^ c[6] ^ c[7], c[1] ^ c[3] ^ c[5] ^ c[7]};
      if (s != 0) c[s] = ~c[s];
      return {s != 0, c[7], c[6], c[5], c[3]};
   endfunction

   function automatic logic [4:0] respond(input int m, input logic [3:0] d, input logic [2:0] i);
      logic [4:0] r;
      r = chain(d, i);
      if (m == 1) r[3:0] = 4'd0;
      if (m == 2) r[4] = 1'b0;
      if (m == 3 && fault_mask[{d, i}]) r[0] = ~r[0];
      return r;
   endfunction

   // one-cycle chain latency
   always @(posedge clk) {err_flag, decoded_data} <= respond(mode, data_word, corrupt_indx);

   task automatic sweep(input string tag, input int m, input bit extra);
      int exp_cnt, exp_fd, exp_fi, busy_n, busy_first, busy_last, done_n, done_at;
      logic [4:0] r;
      mode = m;
      exp_cnt = 0; exp_fd = 0; exp_fi = 0;
      for (int d = 0; d < 16; d++)
         for (int i = 0; i < 8; i++) begin
            r = respond(m, 4'(d), 3'(i));
            if (r[3:0] != 4'(d) || r[4] != (i != 0)) begin
               if (exp_cnt == 0) begin exp_fd = d; exp_fi = i; end
               exp_cnt++;
            end
         end
      busy_n = 0; busy_first = -1; busy_last = -1; done_n = 0; done_at = -1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (busy) begin
            busy_n++;
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = c;
         end
         start = extra && (c == 10 || c == 257);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, " busy_first"}, busy_first, 1);
      check({tag, " busy_last"}, busy_last, 256);
      check({tag, " busy_cycles"}, busy_n, 256);
      check({tag, " done_at"}, done_at, 257);
      check({tag, " done_pulses"}, done_n, 1);
      check({tag, " pass"}, pass, exp_cnt == 0);
      check({tag, " err_cnt"}, err_cnt, exp_cnt > 255 ? 255 : exp_cnt);
      check({tag, " fail_data"}, fail_data, exp_fd);
      check({tag, " fail_indx"}, fail_indx, exp_fi);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst pass", pass, 0);
      check("rst err_cnt", err_cnt, 0);
      check("rst data_word", data_word, 0);
      check("rst corrupt_indx", corrupt_indx, 0);
      check("rst fail", {fail_data, fail_indx}, 0);

      sweep("ideal", 0, 1'b0);
      sweep("data_stuck0", 1, 1'b0);
      check("data_stuck0 model", err_cnt, 120);
      sweep("flag_stuck0", 2, 1'b0);
      check("flag_stuck0 model", err_cnt, 112);
      sweep("ideal_extra_starts", 0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         fault_mask = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
         sweep($sformatf("random%0d", k), 3, 1'b0);
      end

      begin
         int n_done;
         mode = 1;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (79) @(posedge clk);
         #1;
         check("pre_reset busy", busy, 1);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         check("midrst outputs",
               {busy, done, pass, err_cnt, fail_data, fail_indx, data_word, corrupt_indx}, 0);
         n_done = 0;
         for (int c = 0; c < 300; c++) begin
            n_done += done;
            @(posedge clk); #1;
         end
         check("midrst no_done", n_done, 0);
      end
      sweep("after_reset", 0, 1'b0);

      begin
         int w;
         start4 = 1'b1;
         @(posedge clk); #1;
         start4 = 1'b0;
         w = 0;
         while (!done4 && w < 400) begin
            @(posedge clk); #1;
            w++;
         end
         check("sat done_seen", done4, 1);
         check("sat err_cnt", ec4, 15);
         check("sat pass", pass4, 0);
         check("sat fail", {fd4, fi4}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
